// File: rtl/afifo_wr_arb.sv
// Round-robin burst arbiter for the write port of an asynchronous FIFO.
// A burst is granted only when the FIFO has room for every beat, so it never stalls on full.
module afifo_wr_arb #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 8,
    parameter int LW   = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*LW-1:0] len_i,
    output logic [NREQ-1:0]    gnt_o,
    input  logic [NREQ-1:0]    valid_i,
    input  logic [NREQ*DW-1:0] data_i,
    output logic [NREQ-1:0]    ready_o,
    output logic               fifo_we_o,
    output logic [DW-1:0]      fifo_d_o,
    input  logic               fifo_wfull_i,
    input  logic [AW:0]        fifo_wcnt_i,
    output logic               busy_o,
    output logic [IDW-1:0]     cur_id_o
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [AW+1:0] DEPTH = (AW+2)'(2**AW);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [LW-1:0]    cnt_q, cnt_d;

    logic [LW-1:0]    len_arr  [NREQ];
    logic [DW-1:0]    data_arr [NREQ];
    logic [AW+1:0]    need_arr [NREQ];
    logic [NREQ-1:0]  elig;
    logic             win_found;
    logic [IDW-1:0]   win_idx;

    // Widened occupancy sum so wcnt + len + 1 cannot wrap before the compare.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign len_arr[gi]  = len_i[gi*LW +: LW];
            assign data_arr[gi] = data_i[gi*DW +: DW];
            assign need_arr[gi] = {1'b0, fifo_wcnt_i} + (AW+2)'(len_arr[gi]) + (AW+2)'(1);
            assign elig[gi]     = req_i[gi] & (need_arr[gi] <= DEPTH);
        end
    endgenerate

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            cur_id_q <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            cur_id_q <= cur_id_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cur_id_d = cur_id_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = BURST;
                    gnt_d    = NREQ'(1) << win_idx;
                    cur_id_d = win_idx;
                    cnt_d    = len_arr[win_idx];
                end
            end
            BURST: begin
                if (fifo_we_o) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        rr_d    = (cur_id_q == IDW'(NREQ-1)) ? '0 : cur_id_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Full still gates the write even though eligibility should make it unreachable.
    always_comb begin
        ready_o   = '0;
        fifo_we_o = 1'b0;
        fifo_d_o  = data_arr[cur_id_q];
        if (state_q == BURST) begin
            ready_o   = gnt_q & {NREQ{~fifo_wfull_i}};
            fifo_we_o = valid_i[cur_id_q] & ready_o[cur_id_q];
        end
    end

    assign gnt_o    = gnt_q;
    assign busy_o   = (state_q == BURST);
    assign cur_id_o = cur_id_q;

endmodule
